// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the generic rv32i pipeline stage register:
//   - state_t      : occupancy of a stage (EMPTY / HALF / FULL)
//   - DEF_*        : default bundle and counter widths
//   - NOP_CTRL     : control bundle presented for a bubble (all zero)
// No ports (package).
// -----------------------------------------------------------------------------
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,   // no entry held
        ST_HALF  = 2'd1,   // main entry valid
        ST_FULL  = 2'd2    // main + skid entries valid
    } state_t;

    localparam int DEF_CTRL_W = 8;
    localparam int DEF_DATA_W = 128;
    localparam int DEF_CNT_W  = 16;

    // Wide enough for any realistic control bundle; sliced to CTRL_W at use.
    localparam int            NOP_MAX_W = 256;
    localparam logic [NOP_MAX_W-1:0] NOP_CTRL = '0;

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter used for pipeline profiling.
// Ports:
//   clk      in   rising-edge clock
//   reset_n  in   asynchronous active-low reset (count -> 0)
//   inc      in   count up by one this cycle (sticks at all-ones)
//   clr      in   synchronous clear, wins over inc
//   count    out  CNT_W-bit current count
// -----------------------------------------------------------------------------
module sat_counter
    import pipe_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + ONE;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= sat_inc(count);
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
// Generic pipeline stage register: control + data bundles with a valid/ready
// handshake, flush (bubble insertion) and saturating stall/flush counters.
// SKID=1 adds a second entry so in_ready comes straight from flops and the
// ready path between stages is broken; SKID=0 is a single register whose
// in_ready follows out_ready combinationally.
// Ports:
//   clk, reset_n          clock (rising) / async active-low reset
//   flush                 kill held entries, drop same-cycle input
//   in_valid/in_ready     upstream handshake
//   in_ctrl/in_data       upstream bundles
//   out_valid/out_ready   downstream handshake
//   out_ctrl/out_data     downstream bundles (out_ctrl is 0 when not valid)
//   cnt_clear             synchronous clear of both counters
//   stall_cnt             cycles with out_valid & ~out_ready (not flushing)
//   flush_cnt             flush cycles that killed at least one entry
// -----------------------------------------------------------------------------
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W     = DEF_CTRL_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int SKID       = 1,
    parameter int CLEAR_DATA = 1,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    input  logic              cnt_clear,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [CTRL_W-1:0] NOP = NOP_CTRL[CTRL_W-1:0];

    state_t            state;
    logic              vld_p1;
    logic [CTRL_W-1:0] main_ctrl_p1;
    logic [DATA_W-1:0] main_data_p1;
    logic [CTRL_W-1:0] skid_ctrl_p1;
    logic [DATA_W-1:0] skid_data_p1;
    logic              in_fire;

    // ---- stage boundary: upstream -> main/skid registers ----
    generate
        if (SKID != 0) begin : g_skid
            assign in_ready = (state != ST_FULL);
        end else begin : g_noskid
            // With no skid entry the FSM never leaves EMPTY/HALF.
            assign in_ready = out_ready | ~vld_p1;
        end
    endgenerate

    assign in_fire = in_valid & in_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_EMPTY;
            main_ctrl_p1 <= '0;
            main_data_p1 <= '0;
            skid_ctrl_p1 <= '0;
            skid_data_p1 <= '0;
        end else if (flush) begin
            // Same-cycle input is dropped even if in_fire was high.
            state        <= ST_EMPTY;
            main_ctrl_p1 <= NOP;
            skid_ctrl_p1 <= NOP;
            if (CLEAR_DATA != 0) begin
                main_data_p1 <= '0;
                skid_data_p1 <= '0;
            end
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_ctrl_p1 <= in_ctrl;
                        main_data_p1 <= in_data;
                        state        <= ST_HALF;
                    end
                end
                ST_HALF: begin
                    if (in_fire && out_ready) begin
                        main_ctrl_p1 <= in_ctrl;
                        main_data_p1 <= in_data;
                    end else if (in_fire) begin
                        skid_ctrl_p1 <= in_ctrl;
                        skid_data_p1 <= in_data;
                        state        <= ST_FULL;
                    end else if (out_ready) begin
                        state <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only the drain can happen.
                    if (out_ready) begin
                        main_ctrl_p1 <= skid_ctrl_p1;
                        main_data_p1 <= skid_data_p1;
                        state        <= ST_HALF;
                    end
                end
                default: state <= ST_EMPTY;
            endcase
        end
    end

    // ---- stage boundary: main register -> downstream ----
    assign vld_p1    = (state != ST_EMPTY);
    assign out_valid = vld_p1;
    // Bubble shows up as a NOP even to consumers that ignore out_valid.
    assign out_ctrl  = vld_p1 ? main_ctrl_p1 : NOP;
    assign out_data  = main_data_p1;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (vld_p1 & ~out_ready & ~flush),
        .clr     (cnt_clear),
        .count   (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (flush & vld_p1),
        .clr     (cnt_clear),
        .count   (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
// Two instances: A (SKID=1, CLEAR_DATA=1, 4-bit counters) and
// B (SKID=0, CLEAR_DATA=0, 16-bit counters). Accepted entries go into a
// per-instance queue; every downstream transfer pops and compares.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

    localparam int CW = 8;
    localparam int DW = 32;

    logic clk;
    logic reset_n;

    logic          a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_cnt_clear;
    logic [CW-1:0] a_in_ctrl, a_out_ctrl;
    logic [DW-1:0] a_in_data, a_out_data;
    logic [3:0]    a_stall_cnt, a_flush_cnt;

    logic          b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_cnt_clear;
    logic [CW-1:0] b_in_ctrl, b_out_ctrl;
    logic [DW-1:0] b_in_data, b_out_data;
    logic [15:0]   b_stall_cnt, b_flush_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    logic a_acc, b_acc;
    logic [CW+DW-1:0] q_a[$];
    logic [CW+DW-1:0] q_b[$];

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CLEAR_DATA(1), .CNT_W(4)) dut_a (
        .clk(clk), .reset_n(reset_n), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_ctrl(a_in_ctrl), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_ctrl(a_out_ctrl), .out_data(a_out_data),
        .cnt_clear(a_cnt_clear), .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
    );

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .CLEAR_DATA(0), .CNT_W(16)) dut_b (
        .clk(clk), .reset_n(reset_n), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_ctrl(b_in_ctrl), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_ctrl(b_out_ctrl), .out_data(b_out_data),
        .cnt_clear(b_cnt_clear), .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [CW-1:0] mk_ctrl(input logic [DW-1:0] d);
        return {d[6:0], 1'b1};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_a(input logic v, input logic [DW-1:0] d);
        a_in_valid = v;
        a_in_data  = d;
        a_in_ctrl  = mk_ctrl(d);
    endtask

    task automatic set_b(input logic v, input logic [DW-1:0] d);
        b_in_valid = v;
        b_in_data  = d;
        b_in_ctrl  = mk_ctrl(d);
    endtask

    // Sample handshakes just before the edge, update scoreboards, advance.
    task automatic tick();
        logic [CW+DW-1:0] e;
        #1;
        if (a_out_valid && a_out_ready) begin
            check("a_out_expected", (q_a.size() != 0), 1);
            if (q_a.size() != 0) begin
                e = q_a.pop_front();
                check("a_out_data", a_out_data, e[DW-1:0]);
                check("a_out_ctrl", a_out_ctrl, e[CW+DW-1:DW]);
            end
        end
        a_acc = a_in_valid && a_in_ready && !a_flush;
        if (a_flush) q_a.delete();
        if (a_acc) q_a.push_back({a_in_ctrl, a_in_data});

        if (b_out_valid && b_out_ready) begin
            check("b_out_expected", (q_b.size() != 0), 1);
            if (q_b.size() != 0) begin
                e = q_b.pop_front();
                check("b_out_data", b_out_data, e[DW-1:0]);
                check("b_out_ctrl", b_out_ctrl, e[CW+DW-1:DW]);
            end
        end
        b_acc = b_in_valid && b_in_ready && !b_flush;
        if (b_flush) q_b.delete();
        if (b_acc) q_b.push_back({b_in_ctrl, b_in_data});

        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input logic [DW-1:0] d);
        set_a(1'b1, d);
        tick();
        check("a_push_acc", a_acc, 1);
        set_a(1'b0, '0);
    endtask

    task automatic drain();
        a_out_ready = 1'b1;
        b_out_ready = 1'b1;
        set_a(1'b0, '0);
        set_b(1'b0, '0);
        for (int k = 0; k < 8 && (q_a.size() != 0 || q_b.size() != 0); k++) tick();
        check("drain_a", q_a.size(), 0);
        check("drain_b", q_b.size(), 0);
    endtask

    initial begin
        reset_n = 1'b0;
        a_flush = 1'b0; a_out_ready = 1'b0; a_cnt_clear = 1'b0; set_a(1'b0, '0);
        b_flush = 1'b0; b_out_ready = 1'b0; b_cnt_clear = 1'b0; set_b(1'b0, '0);
        a_acc = 1'b0; b_acc = 1'b0;
        #12 reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset state
        check("rst_a_out_valid", a_out_valid, 0);
        check("rst_a_in_ready", a_in_ready, 1);
        check("rst_a_out_ctrl", a_out_ctrl, 0);
        check("rst_a_out_data", a_out_data, 0);
        check("rst_a_stall_cnt", a_stall_cnt, 0);
        check("rst_a_flush_cnt", a_flush_cnt, 0);
        check("rst_b_out_valid", b_out_valid, 0);
        check("rst_b_in_ready", b_in_ready, 1);

        // Streaming 0x1..0x8 back-to-back on both instances
        a_out_ready = 1'b1;
        b_out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            set_a(1'b1, DW'(i));
            set_b(1'b1, DW'(i));
            tick();
            check("stream_a_acc", a_acc, 1);
            check("stream_b_acc", b_acc, 1);
            check("stream_a_lat", a_out_data, i);
            check("stream_b_lat", b_out_data, i);
        end
        drain();
        check("stream_a_stall", a_stall_cnt, 0);
        check("stream_b_stall", b_stall_cnt, 0);

        // Back-pressure on the skid instance: 0xA main, 0xB skid, 0xC held
        a_out_ready = 1'b0;
        push_a(32'hA);
        push_a(32'hB);
        check("bp_a_main", a_out_data, 32'hA);
        check("bp_a_in_ready", a_in_ready, 0);
        check("bp_a_out_valid", a_out_valid, 1);
        set_a(1'b1, 32'hC);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("bp_a_c_held", a_acc, 0);
        end
        check("bp_a_stall_cnt", a_stall_cnt, 4);
        a_out_ready = 1'b1;
        begin
            logic got;
            got = 1'b0;
            for (int k = 0; k < 5 && !got; k++) begin
                tick();
                got = a_acc;
            end
            check("bp_a_c_accepted", got, 1);
        end
        drain();
        check("bp_a_stall_after", a_stall_cnt, 4);

        // Flush in FULL with 0xD offered
        a_out_ready = 1'b0;
        push_a(32'h11);
        push_a(32'h12);
        check("fl_a_full", a_in_ready, 0);
        set_a(1'b1, 32'hD);
        a_flush = 1'b1;
        tick();
        a_flush = 1'b0;
        set_a(1'b0, '0);
        check("fl_a_out_valid", a_out_valid, 0);
        check("fl_a_out_ctrl", a_out_ctrl, 0);
        check("fl_a_in_ready", a_in_ready, 1);
        check("fl_a_out_data", a_out_data, 0);
        check("fl_a_flush_cnt", a_flush_cnt, 1);
        check("fl_a_stall_cnt", a_stall_cnt, 5);
        // Flush while EMPTY leaves the counter alone
        a_flush = 1'b1;
        tick();
        a_flush = 1'b0;
        check("fl_a_empty_cnt", a_flush_cnt, 1);
        // 0xD must never come out; only 0xE follows
        a_out_ready = 1'b1;
        push_a(32'hE);
        drain();

        // Saturation of the 4-bit stall counter and clear priority
        a_cnt_clear = 1'b1;
        tick();
        a_cnt_clear = 1'b0;
        check("sat_a_clr_stall", a_stall_cnt, 0);
        check("sat_a_clr_flush", a_flush_cnt, 0);
        a_out_ready = 1'b0;
        push_a(32'h21);
        for (int k = 0; k < 20; k++) tick();
        check("sat_a_stall_15", a_stall_cnt, 15);
        a_cnt_clear = 1'b1;
        tick();
        a_cnt_clear = 1'b0;
        check("sat_a_clr_wins", a_stall_cnt, 0);
        tick();
        check("sat_a_resume", a_stall_cnt, 1);
        drain();

        // Asynchronous reset with the skid instance FULL
        a_out_ready = 1'b0;
        push_a(32'h31);
        push_a(32'h32);
        check("rm_a_full", a_in_ready, 0);
        #2 reset_n = 1'b0;
        #1;
        check("rm_a_out_valid", a_out_valid, 0);
        check("rm_a_out_ctrl", a_out_ctrl, 0);
        check("rm_a_stall_cnt", a_stall_cnt, 0);
        check("rm_a_in_ready", a_in_ready, 1);
        q_a.delete();
        q_b.delete();
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;
        a_out_ready = 1'b1;
        push_a(32'h41);
        drain();

        // Non-skid instance: combinational ready and flush holding data
        b_out_ready = 1'b0;
        set_b(1'b1, 32'h55);
        tick();
        check("b_push_acc", b_acc, 1);
        set_b(1'b0, '0);
        check("b_in_ready_stalled", b_in_ready, 0);
        b_out_ready = 1'b1;
        #1;
        check("b_in_ready_comb", b_in_ready, 1);
        b_out_ready = 1'b0;
        set_b(1'b1, 32'h66);
        b_flush = 1'b1;
        tick();
        b_flush = 1'b0;
        set_b(1'b0, '0);
        check("b_fl_out_valid", b_out_valid, 0);
        check("b_fl_out_ctrl", b_out_ctrl, 0);
        check("b_fl_out_data", b_out_data, 32'h55);
        check("b_fl_flush_cnt", b_flush_cnt, 1);
        check("b_fl_stall_cnt", b_stall_cnt, 0);
        check("b_fl_in_ready", b_in_ready, 1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
